player_rockets_unit: RTL and testbench

- Source side of the per-object drawing-request/RGB interface. Owns a pool of player rocket slots.
- Launches a rocket on a fire keypress and moves each live rocket up once per frame.
- Retires a rocket on a hit or on reaching the top of the screen.
- Drives one drawing-request bit and one 8-bit RGB per slot to the priority objects mux, from the current VGA pixel coordinates.

---
 rtl/rockets_pkg.sv | 9 +
 rtl/rocket_slot.sv | 97 +++++++++
 rtl/player_rockets_unit.sv | 96 +++++++++
 tb/tb_player_rockets_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rockets_pkg.sv
// Shared types and constants for the player rocket pool.
// Coordinates are unsigned 11-bit values. The extra sign bit is added only where subtraction can go negative.
package rockets_pkg;
   typedef enum logic {R_IDLE, R_FLYING} rocket_state_t;

   localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;
   localparam int         COORD_W              = 11;
   localparam int         PLAYER_W             = 32;
endpackage

// File: rtl/rocket_slot.sv
// One rocket: IDLE/FLYING state, position, per-frame upward movement and a registered bounding-box draw.
// A launch is only ever presented to an IDLE slot, so launch and flight updates never collide.
module rocket_slot
   import rockets_pkg::*;
#(
   parameter int         ROCKET_W     = 4,
   parameter int         ROCKET_H     = 12,
   parameter int         SPEED        = 4,
   parameter int         SCREEN_TOP   = 0,
   parameter logic [7:0] ROCKET_COLOR = 8'hFC
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic                      i_launch,
   input  logic [COORD_W-1:0]        i_launch_x,
   input  logic signed [COORD_W:0]   i_launch_y,
   input  logic                      i_sof,
   input  logic                      i_hit,
   input  logic [COORD_W-1:0]        i_pixel_x,
   input  logic [COORD_W-1:0]        i_pixel_y,
   output logic                      o_dr,
   output logic [7:0]                o_rgb,
   output logic                      o_active
);
   localparam logic signed [COORD_W:0] L_SPEED = (COORD_W+1)'(SPEED);
   localparam logic signed [COORD_W:0] L_TOP   = (COORD_W+1)'(SCREEN_TOP);
   localparam logic signed [COORD_W:0] L_H     = (COORD_W+1)'(ROCKET_H);
   localparam logic [COORD_W:0]        L_W     = (COORD_W+1)'(ROCKET_W);

   rocket_state_t           r_state, w_state_next;
   logic [COORD_W-1:0]      r_x, w_x_next;
   logic signed [COORD_W:0] r_y, w_y_next;
   logic signed [COORD_W:0] w_y_moved;
   logic [COORD_W:0]        w_px, w_x12, w_x_end;
   logic signed [COORD_W:0] w_py, w_y_end;
   logic                    w_inside;

   assign w_y_moved = r_y - L_SPEED;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state <= R_IDLE;
         r_x     <= '0;
         r_y     <= '0;
      end else begin
         r_state <= w_state_next;
         r_x     <= w_x_next;
         r_y     <= w_y_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_x_next     = r_x;
      w_y_next     = r_y;
      case (r_state)
         R_IDLE: begin
            if (i_launch) begin
               w_state_next = R_FLYING;
               w_x_next     = i_launch_x;
               w_y_next     = i_launch_y;
            end
         end
         R_FLYING: begin
            // A hit wins over the frame tick. Leaving the top wins over moving.
            if (i_hit)
               w_state_next = R_IDLE;
            else if (i_sof && (w_y_moved < L_TOP))
               w_state_next = R_IDLE;
            else if (i_sof)
               w_y_next = w_y_moved;
         end
         default: w_state_next = R_IDLE;
      endcase
   end

   // The bounds use 12 bits so that x+ROCKET_W cannot wrap at the right edge.
   assign w_px     = {1'b0, i_pixel_x};
   assign w_x12    = {1'b0, r_x};
   assign w_x_end  = w_x12 + L_W;
   assign w_py     = $signed({1'b0, i_pixel_y});
   assign w_y_end  = r_y + L_H;
   assign w_inside = (r_state == R_FLYING) && (w_px >= w_x12) && (w_px < w_x_end)
                     && (w_py >= r_y) && (w_py < w_y_end);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         o_dr  <= 1'b0;
         o_rgb <= TRANSPARENT_ENCODING;
      end else begin
         o_dr  <= w_inside;
         o_rgb <= w_inside ? ROCKET_COLOR : TRANSPARENT_ENCODING;
      end
   end

   assign o_active = (r_state == R_FLYING);
endmodule

// File: rtl/player_rockets_unit.sv
// Player rocket pool: fire-edge detection, cooldown and a lowest-index-free allocator.
// The allocator feeds NUM_ROCKETS rocket_slot instances.
module player_rockets_unit
   import rockets_pkg::*;
#(
   parameter int         NUM_ROCKETS     = 2,
   parameter int         ROCKET_W        = 4,
   parameter int         ROCKET_H        = 12,
   parameter int         SPEED           = 4,
   parameter int         SCREEN_TOP      = 0,
   parameter logic [7:0] ROCKET_COLOR    = 8'hFC,
   parameter int         COOLDOWN_FRAMES = 8
) (
   input  logic                       clk,
   input  logic                       resetN,
   input  logic                       startOfFrame,
   input  logic                       fire,
   input  logic [COORD_W-1:0]         playerX,
   input  logic [COORD_W-1:0]         playerY,
   input  logic [COORD_W-1:0]         pixelX,
   input  logic [COORD_W-1:0]         pixelY,
   input  logic [NUM_ROCKETS-1:0]     hit,
   output logic [NUM_ROCKETS-1:0]     rockets_DR,
   output logic [8*NUM_ROCKETS-1:0]   rockets_RGB,
   output logic [NUM_ROCKETS-1:0]     active
);
   localparam int                      CD_W    = $clog2(COOLDOWN_FRAMES + 1);
   localparam logic signed [COORD_W:0] L_TOP   = (COORD_W+1)'(SCREEN_TOP);
   localparam logic signed [COORD_W:0] L_H     = (COORD_W+1)'(ROCKET_H);
   localparam logic [COORD_W-1:0]      L_X_OFS = COORD_W'(PLAYER_W/2 - ROCKET_W/2);

   logic                    r_fire_d;
   logic [CD_W-1:0]         r_cooldown;
   logic                    w_fire_req, w_found, w_y_ok, w_launch;
   logic [NUM_ROCKETS-1:0]  w_sel, w_slot_launch;
   logic [COORD_W-1:0]      w_launch_x;
   logic signed [COORD_W:0] w_launch_y;

   assign w_fire_req = fire & ~r_fire_d;
   assign w_launch_x = playerX + L_X_OFS;
   assign w_launch_y = $signed({1'b0, playerY}) - L_H;
   assign w_y_ok     = (w_launch_y >= L_TOP);

   // The allocator reads the registered slot states, so a slot freed by a hit this cycle is not reused until the next.
   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      for (int i = 0; i < NUM_ROCKETS; i++) begin
         if (!active[i] && !w_found) begin
            w_sel[i] = 1'b1;
            w_found  = 1'b1;
         end
      end
   end

   assign w_launch      = w_fire_req && (r_cooldown == '0) && w_found && w_y_ok;
   assign w_slot_launch = w_launch ? w_sel : '0;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_fire_d   <= 1'b0;
         r_cooldown <= '0;
      end else begin
         r_fire_d <= fire;
         if (w_launch)
            r_cooldown <= CD_W'(COOLDOWN_FRAMES);
         else if (startOfFrame && (r_cooldown != '0))
            r_cooldown <= r_cooldown - 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_ROCKETS; gi++) begin : g_slot
         rocket_slot #(
            .ROCKET_W     (ROCKET_W),
            .ROCKET_H     (ROCKET_H),
            .SPEED        (SPEED),
            .SCREEN_TOP   (SCREEN_TOP),
            .ROCKET_COLOR (ROCKET_COLOR)
         ) u_slot (
            .clk        (clk),
            .resetN     (resetN),
            .i_launch   (w_slot_launch[gi]),
            .i_launch_x (w_launch_x),
            .i_launch_y (w_launch_y),
            .i_sof      (startOfFrame),
            .i_hit      (hit[gi]),
            .i_pixel_x  (pixelX),
            .i_pixel_y  (pixelY),
            .o_dr       (rockets_DR[gi]),
            .o_rgb      (rockets_RGB[8*gi +: 8]),
            .o_active   (active[gi])
         );
      end
   endgenerate
endmodule

// File: tb/tb_player_rockets_unit.sv
// Directed bench for player_rockets_unit with hand-computed positions.
// Each rocket's position is checked through the registered drawing outputs.
module tb_player_rockets_unit;
   logic        clk = 1'b0;
   logic        resetN, startOfFrame, fire;
   logic [10:0] playerX, playerY, pixelX, pixelY;
   logic [1:0]  hit, rockets_DR, active;
   logic [15:0] rockets_RGB;
   int          n_pass = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   player_rockets_unit dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fire(fire),
      .playerX(playerX), .playerY(playerY), .pixelX(pixelX), .pixelY(pixelY),
      .hit(hit), .rockets_DR(rockets_DR), .rockets_RGB(rockets_RGB), .active(active)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sof_pulse(input int n);
      for (int k = 0; k < n; k++) begin
         startOfFrame = 1'b1;
         tick();
         startOfFrame = 1'b0;
         tick();
      end
   endtask

   task automatic fire_edge();
      fire = 1'b1;
      tick();
      fire = 1'b0;
      tick();
   endtask

   task automatic probe(input int x, input int y);
      pixelX = 11'(x);
      pixelY = 11'(y);
      tick();
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      tick();
      resetN = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      #3;
      n_total++; if (rockets_DR !== 2'b00) $display("FAIL reset_dr: got %b expected 00", rockets_DR); else n_pass++;
      n_total++; if (rockets_RGB !== 16'hFFFF) $display("FAIL reset_rgb: got %h expected ffff", rockets_RGB); else n_pass++;
      n_total++; if (active !== 2'b00) $display("FAIL reset_active: got %b expected 00", active); else n_pass++;
      tick();
      resetN = 1'b1;
      tick();
   endtask

   task automatic test_launch();
      playerX = 11'd300; playerY = 11'd440;
      fire = 1'b1;
      tick();
      n_total++; if (active !== 2'b01) $display("FAIL launch_active: got %b expected 01", active); else n_pass++;
      fire = 1'b0;
      tick();
      probe(315, 430);
      n_total++; if (rockets_DR !== 2'b01) $display("FAIL launch_dr_in: got %b expected 01", rockets_DR); else n_pass++;
      n_total++; if (rockets_RGB !== 16'hFFFC) $display("FAIL launch_rgb_in: got %h expected fffc", rockets_RGB); else n_pass++;
      probe(318, 430);
      n_total++; if (rockets_DR !== 2'b00) $display("FAIL launch_dr_right: got %b expected 00", rockets_DR); else n_pass++;
      n_total++; if (rockets_RGB !== 16'hFFFF) $display("FAIL launch_rgb_right: got %h expected ffff", rockets_RGB); else n_pass++;
      probe(313, 430);
      n_total++; if (rockets_DR !== 2'b00) $display("FAIL launch_dr_left: got %b expected 00", rockets_DR); else n_pass++;
      probe(314, 428);
      n_total++; if (rockets_DR !== 2'b01) $display("FAIL launch_dr_corner: got %b expected 01", rockets_DR); else n_pass++;
      probe(315, 427);
      n_total++; if (rockets_DR !== 2'b00) $display("FAIL launch_dr_above: got %b expected 00", rockets_DR); else n_pass++;
      probe(315, 439);
      n_total++; if (rockets_DR !== 2'b01) $display("FAIL launch_dr_bottom: got %b expected 01", rockets_DR); else n_pass++;
      probe(315, 440);
      n_total++; if (rockets_DR !== 2'b00) $display("FAIL launch_dr_below: got %b expected 00", rockets_DR); else n_pass++;
   endtask

   task automatic test_move();
      sof_pulse(3);
      probe(315, 416);
      n_total++; if (rockets_DR !== 2'b01) $display("FAIL move_dr_top: got %b expected 01", rockets_DR); else n_pass++;
      probe(315, 415);
      n_total++; if (rockets_DR !== 2'b00) $display("FAIL move_dr_above: got %b expected 00", rockets_DR); else n_pass++;
   endtask

   task automatic test_hold();
      // The cooldown still has 5 frames left, so this edge is dropped. Holding the key past expiry must not retry it.
      fire = 1'b1;
      tick();
      sof_pulse(20);
      fire = 1'b0;
      tick();
      n_total++; if (active !== 2'b01) $display("FAIL hold_active: got %b expected 01", active); else n_pass++;
   endtask

   task automatic test_two_slots();
      fire_edge();
      n_total++; if (active !== 2'b11) $display("FAIL two_active: got %b expected 11", active); else n_pass++;
      sof_pulse(9);
      fire_edge();
      n_total++; if (active !== 2'b11) $display("FAIL full_drop_active: got %b expected 11", active); else n_pass++;
      probe(315, 392);
      n_total++; if (rockets_DR !== 2'b10) $display("FAIL slot1_dr: got %b expected 10", rockets_DR); else n_pass++;
      n_total++; if (rockets_RGB !== 16'hFCFF) $display("FAIL slot1_rgb: got %h expected fcff", rockets_RGB); else n_pass++;
      probe(315, 300);
      n_total++; if (rockets_DR !== 2'b01) $display("FAIL slot0_moved_dr: got %b expected 01", rockets_DR); else n_pass++;
   endtask

   task automatic test_top_exit();
      do_reset();
      playerX = 11'd300; playerY = 11'd11;
      fire_edge();
      n_total++; if (active !== 2'b00) $display("FAIL neg_y_drop: got %b expected 00", active); else n_pass++;
      playerY = 11'd18;
      fire_edge();
      n_total++; if (active !== 2'b01) $display("FAIL y6_launch: got %b expected 01", active); else n_pass++;
      probe(315, 6);
      n_total++; if (rockets_DR !== 2'b01) $display("FAIL y6_dr: got %b expected 01", rockets_DR); else n_pass++;
      sof_pulse(1);
      probe(315, 2);
      n_total++; if (rockets_DR !== 2'b01) $display("FAIL y2_dr: got %b expected 01", rockets_DR); else n_pass++;
      probe(315, 1);
      n_total++; if (rockets_DR !== 2'b00) $display("FAIL y2_above: got %b expected 00", rockets_DR); else n_pass++;
      sof_pulse(1);
      n_total++; if (active !== 2'b00) $display("FAIL exit_active: got %b expected 00", active); else n_pass++;
      probe(315, 2);
      n_total++; if (rockets_DR !== 2'b00) $display("FAIL exit_dr: got %b expected 00", rockets_DR); else n_pass++;
      sof_pulse(6);
      playerY = 11'd12;
      fire_edge();
      n_total++; if (active !== 2'b01) $display("FAIL y0_launch: got %b expected 01", active); else n_pass++;
      probe(315, 0);
      n_total++; if (rockets_DR !== 2'b01) $display("FAIL y0_dr: got %b expected 01", rockets_DR); else n_pass++;
      sof_pulse(1);
      n_total++; if (active !== 2'b00) $display("FAIL y0_exit: got %b expected 00", active); else n_pass++;
   endtask

   task automatic test_hit_sof();
      do_reset();
      playerX = 11'd300; playerY = 11'd440;
      fire_edge();
      sof_pulse(9);
      fire_edge();
      sof_pulse(8);
      n_total++; if (active !== 2'b11) $display("FAIL hit_setup: got %b expected 11", active); else n_pass++;
      hit = 2'b01; startOfFrame = 1'b1; fire = 1'b1;
      tick();
      hit = 2'b00; startOfFrame = 1'b0;
      n_total++; if (active !== 2'b10) $display("FAIL hit_sof_active: got %b expected 10", active); else n_pass++;
      tick();
      fire = 1'b0;
      tick();
      n_total++; if (active !== 2'b10) $display("FAIL hit_no_queue: got %b expected 10", active); else n_pass++;
      hit = 2'b10;
      tick();
      hit = 2'b00;
      fire = 1'b1; hit = 2'b00; startOfFrame = 1'b1;
      tick();
      fire = 1'b0; startOfFrame = 1'b0;
      tick();
      n_total++; if (active !== 2'b01) $display("FAIL relaunch_active: got %b expected 01", active); else n_pass++;
      probe(315, 439);
      n_total++; if (rockets_DR !== 2'b01) $display("FAIL relaunch_no_move: got %b expected 01", rockets_DR); else n_pass++;
   endtask

   task automatic test_async_reset();
      sof_pulse(8);
      fire_edge();
      n_total++; if (active !== 2'b11) $display("FAIL ar_setup: got %b expected 11", active); else n_pass++;
      probe(315, 430);
      n_total++; if (rockets_DR !== 2'b10) $display("FAIL ar_pre_dr: got %b expected 10", rockets_DR); else n_pass++;
      #2;
      resetN = 1'b0;
      #1;
      n_total++; if (rockets_DR !== 2'b00) $display("FAIL ar_dr: got %b expected 00", rockets_DR); else n_pass++;
      n_total++; if (rockets_RGB !== 16'hFFFF) $display("FAIL ar_rgb: got %h expected ffff", rockets_RGB); else n_pass++;
      n_total++; if (active !== 2'b00) $display("FAIL ar_active: got %b expected 00", active); else n_pass++;
      tick();
      resetN = 1'b1;
      tick(); tick(); tick();
      n_total++; if (active !== 2'b00) $display("FAIL ar_no_launch: got %b expected 00", active); else n_pass++;
      n_total++; if (rockets_DR !== 2'b00) $display("FAIL ar_post_dr: got %b expected 00", rockets_DR); else n_pass++;
   endtask

   initial begin
      resetN = 1'b0; startOfFrame = 1'b0; fire = 1'b0; hit = 2'b00;
      playerX = '0; playerY = '0; pixelX = '0; pixelY = '0;
      tick();
      test_reset();
      test_launch();
      test_move();
      test_hold();
      test_two_slots();
      test_top_exit();
      test_hit_sof();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
